// File: rtl/pixel_writer.sv
// Pixel writer: queues shaded pixels in a small FIFO and writes each one to the
// frame buffer as little-endian byte writes on an 8-bit Avalon-MM master.
module pixel_writer #(
  parameter int H_RESOLUTION = 256,
  parameter int V_RESOLUTION = 192,
  parameter int PIXEL_BITS   = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           pixel_buffer,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [15:0]           in_row,
  input  logic [15:0]           in_col,
  input  logic [PIXEL_BITS-1:0] in_color,
  output logic [31:0]           m1_address,
  output logic [7:0]            m1_writedata,
  output logic                  m1_write,
  input  logic                  m1_waitrequest,
  output logic                  idle,
  output logic                  dropped
);

  localparam int PIXEL_BYTES = PIXEL_BITS / 8;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int KW = (PIXEL_BYTES > 1) ? $clog2(PIXEL_BYTES) : 1;
  localparam logic [PW:0]   FULL_CNT = FIFO_DEPTH[PW:0];
  localparam logic [KW-1:0] K_LAST   = KW'(PIXEL_BYTES - 1);
  localparam logic [15:0]   H_LIM    = 16'(H_RESOLUTION);
  localparam logic [15:0]   V_LIM    = 16'(V_RESOLUTION);
  localparam logic [31:0]   H_RES32  = 32'(H_RESOLUTION);
  localparam logic [31:0]   BYTES32  = 32'(PIXEL_BYTES);

  typedef enum logic {S_IDLE = 1'b0, S_WRITE = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW:0]           count_q, count_d;
  logic [KW-1:0]         k_q, k_d;
  logic [31:0]           addr_q, addr_d;
  logic [PIXEL_BITS-1:0] color_q, color_d;
  logic                  idle_q, idle_d;
  logic                  dropped_q, dropped_d;

  logic [15:0]           row_mem_q   [FIFO_DEPTH];
  logic [15:0]           row_mem_d   [FIFO_DEPTH];
  logic [15:0]           col_mem_q   [FIFO_DEPTH];
  logic [15:0]           col_mem_d   [FIFO_DEPTH];
  logic [PIXEL_BITS-1:0] color_mem_q [FIFO_DEPTH];
  logic [PIXEL_BITS-1:0] color_mem_d [FIFO_DEPTH];

  logic                  fifo_empty, fifo_full;
  logic                  push, pop, drop, load;
  logic                  head_bad;
  logic [15:0]           head_row, head_col;
  logic [PIXEL_BITS-1:0] head_color;
  logic [31:0]           head_addr;

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FULL_CNT);
    push       = in_valid && !fifo_full;
    head_row   = row_mem_q[rd_ptr_q];
    head_col   = col_mem_q[rd_ptr_q];
    head_color = color_mem_q[rd_ptr_q];
    head_bad   = (head_row >= V_LIM) || (head_col >= H_LIM);
    head_addr  = pixel_buffer + (({16'd0, head_row} * H_RES32) + {16'd0, head_col}) * BYTES32;
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      k_q       <= '0;
      addr_q    <= '0;
      color_q   <= '0;
      idle_q    <= 1'b1;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      k_q       <= k_d;
      addr_q    <= addr_d;
      color_q   <= color_d;
      idle_q    <= idle_d;
      dropped_q <= dropped_d;
    end
  end

  // FIFO storage holds only data, so it needs no reset
  always_ff @(posedge clock) begin
    row_mem_q   <= row_mem_d;
    col_mem_q   <= col_mem_d;
    color_mem_q <= color_mem_d;
  end

  // Next state: pop/drop decisions and byte sequencing
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    addr_d  = addr_q;
    color_d = color_q;
    pop     = 1'b0;
    drop    = 1'b0;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_bad) begin
            drop = 1'b1;
          end else begin
            load    = 1'b1;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (!m1_waitrequest) begin
          if (k_q != K_LAST) begin
            k_d     = k_q + 1'b1;
            addr_d  = addr_q + 32'd1;
            color_d = color_q >> 8;
          end else if (!fifo_empty) begin
            pop = 1'b1;
            if (head_bad) begin
              drop    = 1'b1;
              state_d = S_IDLE;
            end else begin
              load = 1'b1;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      k_d     = '0;
      addr_d  = head_addr;
      color_d = head_color;
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    row_mem_d   = row_mem_q;
    col_mem_d   = col_mem_q;
    color_mem_d = color_mem_q;
    if (push) begin
      row_mem_d[wr_ptr_q]   = in_row;
      col_mem_d[wr_ptr_q]   = in_col;
      color_mem_d[wr_ptr_q] = in_color;
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    dropped_d = drop;
    // idle looks ahead at the next state so it tracks the edge that empties or fills
    idle_d    = (state_d == S_IDLE) && (count_d == '0);
  end

  // Outputs
  always_comb begin
    in_ready     = !fifo_full;
    m1_write     = (state_q == S_WRITE);
    m1_address   = addr_q;
    m1_writedata = color_q[7:0];
    idle         = idle_q;
    dropped      = dropped_q;
  end

endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer: single pixel, stall, backpressure,
// out-of-range drops, address wrap and asynchronous reset mid-write.
module tb_pixel_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pixel_buffer;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_row;
  logic [15:0] in_col;
  logic [15:0] in_color;
  logic [31:0] m1_address;
  logic [7:0]  m1_writedata;
  logic        m1_write;
  logic        m1_waitrequest;
  logic        idle;
  logic        dropped;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
    int          c;
  } wr_t;

  wr_t wq[$];
  int  cyc = 0;
  int  drop_cnt = 0;
  int  n_chk = 0;
  int  n_err = 0;

  pixel_writer #(
    .H_RESOLUTION(256),
    .V_RESOLUTION(192),
    .PIXEL_BITS  (16),
    .FIFO_DEPTH  (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .pixel_buffer  (pixel_buffer),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_row        (in_row),
    .in_col        (in_col),
    .in_color      (in_color),
    .m1_address    (m1_address),
    .m1_writedata  (m1_writedata),
    .m1_write      (m1_write),
    .m1_waitrequest(m1_waitrequest),
    .idle          (idle),
    .dropped       (dropped)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Bus and drop monitor, sampled mid-cycle
  always @(negedge clock) begin
    if (!reset && m1_write && !m1_waitrequest) wq.push_back('{a: m1_address, d: m1_writedata, c: cyc});
    if (!reset && dropped) drop_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_pix(input logic [15:0] r, input logic [15:0] c, input logic [15:0] col);
    bit acc = 1'b0;
    int n = 0;
    in_row   = r;
    in_col   = c;
    in_color = col;
    in_valid = 1'b1;
    while (!acc && n < 50) begin
      acc = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    if (!acc) chk("push_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!idle && n < 200) begin
      tick();
      n++;
    end
    chk(tag, idle, 1);
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [31:0] ea, input logic [7:0] ed);
    logic [39:0] got;
    got = (idx < wq.size()) ? {wq[idx].a, wq[idx].d} : 40'hFF_FFFF_FFFF;
    chk(tag, got, {ea, ed});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    bit a;
    reset          = 1'b1;
    pixel_buffer   = 32'h0;
    in_valid       = 1'b0;
    in_row         = '0;
    in_col         = '0;
    in_color       = '0;
    m1_waitrequest = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    chk("rst_in_ready", in_ready, 1);
    chk("rst_write", m1_write, 0);
    chk("rst_addr", m1_address, 0);
    chk("rst_data", m1_writedata, 0);
    chk("rst_idle", idle, 1);
    chk("rst_dropped", dropped, 0);
    tick();

    // Single pixel with exact latency
    pixel_buffer = 32'h0800_0000;
    push_pix(16'd1, 16'd2, 16'hABCD);
    chk("s1_idle_fall", idle, 0);
    chk("s1_no_write_yet", m1_write, 0);
    tick();
    chk("s1_byte0", {m1_write, m1_address, m1_writedata}, {1'b1, 32'h0800_0204, 8'hCD});
    tick();
    chk("s1_byte1", {m1_write, m1_address, m1_writedata}, {1'b1, 32'h0800_0205, 8'hAB});
    tick();
    chk("s1_write_end", m1_write, 0);
    chk("s1_idle_back", idle, 1);

    // Stall on first byte
    m1_waitrequest = 1'b1;
    push_pix(16'd1, 16'd2, 16'h1234);
    tick();
    for (int j = 0; j < 4; j++) begin
      if (j > 0) tick();
      if (j == 3) m1_waitrequest = 1'b0;
      chk("st_hold", {m1_write, m1_address, m1_writedata}, {1'b1, 32'h0800_0204, 8'h34});
    end
    tick();
    chk("st_byte1", {m1_write, m1_address, m1_writedata}, {1'b1, 32'h0800_0205, 8'h12});
    tick();
    chk("st_end", {m1_write, idle}, {1'b0, 1'b1});

    // Backpressure: 7 offered, 5 fit while the bus stalls
    pixel_buffer   = 32'h1000_0000;
    m1_waitrequest = 1'b1;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = (acc < 7);
      in_row   = 16'd0;
      in_col   = 16'(acc);
      in_color = {8'(8'hA0 + acc), 8'(8'h50 + acc)};
      a = in_ready && in_valid;
      tick();
      if (a) acc++;
    end
    in_valid = 1'b0;
    chk("bp_accepted", acc, 5);
    chk("bp_in_ready", in_ready, 0);
    wq.delete();
    m1_waitrequest = 1'b0;
    wait_idle("bp_idle");
    chk("bp_count", wq.size(), 10);
    for (int i = 0; i < 5; i++) begin
      for (int b = 0; b < 2; b++) begin
        chk_wr("bp_byte", 2 * i + b, 32'h1000_0000 + 32'(2 * i + b),
               (b == 1) ? 8'(8'hA0 + i) : 8'(8'h50 + i));
        if (2 * i + b < wq.size()) chk("bp_gap", wq[2 * i + b].c - wq[0].c, 2 * i + b);
      end
    end

    // Out-of-range rows and columns, including a drop chained from WRITE
    pixel_buffer = 32'h0800_0000;
    wq.delete();
    drop_cnt = 0;
    push_pix(16'd192, 16'd0, 16'hDEAD);
    push_pix(16'd3, 16'd4, 16'hBEEF);
    push_pix(16'd0, 16'd256, 16'hF00D);
    push_pix(16'd191, 16'd255, 16'h1357);
    wait_idle("oor_idle");
    chk("oor_drops", drop_cnt, 2);
    chk("oor_count", wq.size(), 4);
    chk_wr("oor_w0", 0, 32'h0800_0608, 8'hEF);
    chk_wr("oor_w1", 1, 32'h0800_0609, 8'hBE);
    chk_wr("oor_w2", 2, 32'h0801_7FFE, 8'h57);
    chk_wr("oor_w3", 3, 32'h0801_7FFF, 8'h13);

    // Address wrap modulo 2^32
    pixel_buffer = 32'hFFFF_FFFE;
    wq.delete();
    push_pix(16'd0, 16'd0, 16'h2211);
    push_pix(16'd0, 16'd1, 16'h4433);
    wait_idle("wrap_idle");
    chk("wrap_count", wq.size(), 4);
    chk_wr("wrap_w0", 0, 32'hFFFF_FFFE, 8'h11);
    chk_wr("wrap_w1", 1, 32'hFFFF_FFFF, 8'h22);
    chk_wr("wrap_w2", 2, 32'h0000_0000, 8'h33);
    chk_wr("wrap_w3", 3, 32'h0000_0001, 8'h44);

    // Asynchronous reset while a stalled write is in progress
    m1_waitrequest = 1'b1;
    push_pix(16'd5, 16'd5, 16'h7777);
    push_pix(16'd6, 16'd6, 16'h8888);
    chk("rs_write_before", m1_write, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rs_write_drop", m1_write, 0);
    chk("rs_idle", idle, 1);
    chk("rs_addr", m1_address, 0);
    chk("rs_in_ready", in_ready, 1);
    tick();
    reset          = 1'b0;
    m1_waitrequest = 1'b0;
    wq.delete();
    repeat (10) tick();
    chk("rs_no_writes", wq.size(), 0);
    chk("rs_idle_after", idle, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pixel_writer.md
# pixel_writer

Downstream stage of the voxel GPU render path. Accepts shaded pixels (row, column, colour) from the render controller over a valid/ready stream, buffers them in a small FIFO, and writes each one to the pixel buffer in memory as little-endian byte writes on the 8-bit Avalon-MM master `m1`. The control-register block supplies the pixel buffer base address. `idle` tells the controller when every accepted pixel has reached memory, so it can raise the frame-done interrupt.

## Interface
- `H_RESOLUTION`, 256, columns per frame; also the row stride in pixels.
- `V_RESOLUTION`, 192, rows per frame.
- `PIXEL_BITS`, 16, colour width; must be a multiple of 8. `PIXEL_BYTES = PIXEL_BITS/8`.
- `FIFO_DEPTH`, 4, pixel FIFO entries; power of two, ≥ 2.

Ports:
- `clock` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `pixel_buffer` in 32: base byte address of the frame, from the register block.
- `in_valid` in 1: pixel offered.
- `in_ready` out 1: pixel may be accepted.
- `in_row` in 16, `in_col` in 16: pixel coordinates.
- `in_color` in `PIXEL_BITS`: pixel colour.
- `m1_address` out 32, `m1_writedata` out 8, `m1_write` out 1: Avalon master write channel.
- `m1_waitrequest` in 1: slave stall.
- `idle` out 1: FIFO empty and no write in progress.
- `dropped` out 1: one-cycle pulse when an out-of-range pixel is discarded.

## Operation
- Accept: a pixel is pushed when `in_valid && in_ready`. `in_ready = !full`, with no same-cycle pass-through when full.
- Range check at pop: if `row ≥ V_RESOLUTION` or `col ≥ H_RESOLUTION`, the entry is discarded, `dropped` pulses, and no bus write occurs.
- Address at pop: `addr = pixel_buffer + (row*H_RESOLUTION + col)*PIXEL_BYTES`, computed in 32 bits with modulo 2^32 wrap.
  - `pixel_buffer` is sampled at pop.
  - The controller must not change `pixel_buffer` while `idle` is low.
- Byte order: byte k (k = 0..PIXEL_BYTES-1) goes to `addr+k` with data `color[8k+7:8k]`, so the least significant byte is written first.
- FSM states:
  - **IDLE**: if the FIFO is non-empty, pop the head, latch addr/colour, set k=0, and go to WRITE. If the entry is out of range, pulse `dropped` and stay in IDLE.
  - **WRITE**: `m1_write`=1. On a cycle with `m1_waitrequest`=0, the byte is complete.
    - If k < PIXEL_BYTES-1: increment k and stay in WRITE.
    - Else, if the FIFO is non-empty: pop the next entry in the same edge and stay in WRITE with k=0. An out-of-range next entry drops, pulses `dropped`, and goes to IDLE.
    - Else go to IDLE.
- While `m1_waitrequest`=1, `m1_address`, `m1_writedata` and `m1_write` hold stable.
- A push and a pop in the same cycle leave the FIFO count unchanged.
- Capacity: FIFO_DEPTH queued entries plus one in-flight pixel.
- `idle = (state==IDLE) && fifo_empty`, registered from state and count.

## Timing
- Reset values: `in_ready`=1, `m1_write`=0, `m1_address`=0, `m1_writedata`=0, `idle`=1, `dropped`=0, FIFO empty, state IDLE.
- Reset mid-operation clears everything immediately (asynchronous). The partial pixel is abandoned, and `m1_write` falls without waiting for `m1_waitrequest`.
- Latency: a pixel accepted at edge E0 is popped at E1, and `m1_write` is high in the cycle after E1.
- With `m1_waitrequest`=0, each pixel takes PIXEL_BYTES cycles, and consecutive pixels run back-to-back with no bubble.
- `idle` rises the cycle after the last byte completes with the FIFO empty. It falls the cycle after a push.
- `m1_read` is not driven by this block; the top level ties it low.

## Test plan
- **Single pixel:** `pixel_buffer`=0x0800_0000, row 1, col 2, colour 0xABCD, `m1_waitrequest`=0.
  - Expect a write of 0xCD to 0x0800_0204, then 0xAB to 0x0800_0205, in consecutive cycles.
  - `idle` returns to 1 afterwards.
- **Stall:** hold `m1_waitrequest`=1 for 3 cycles on the first byte.
  - Address, data and `m1_write` stay constant for those 4 cycles, then the second byte follows.
- **Backpressure:** hold `m1_waitrequest`=1 and offer 7 pixels.
  - 5 are accepted (1 in flight, 4 queued), then `in_ready`=0.
  - On release, all 10 bytes are written in order with no gaps and no loss.
- **Out-of-range:** push row 192, col 0, followed by a valid pixel.
  - `dropped` pulses once with no bus write for the bad pixel.
  - The valid pixel writes normally.
- **Wrap:** `pixel_buffer`=0xFFFF_FFFE, row 0, col 0.
  - Expect writes to 0xFFFF_FFFE and 0xFFFF_FFFF.
  - With col 1, expect writes to 0x0000_0000 and 0x0000_0001.
- **Reset mid-write:** assert `reset` while `m1_write`=1 and `m1_waitrequest`=1.
  - `m1_write` falls with no clock edge, and `idle`=1.
  - The FIFO is empty: no further writes occur after `reset` is released.
